nn_image_loader: RTL and testbench
==================================

Name: nn_image_loader

Overview:
Front-end feeder for the digit-recognition network. Accepts a raster stream of 8-bit grayscale pixels, binarizes each against a threshold and packs them into the 28x28 one-bit image vector. Presents the image to the inference core with a valid/ready handshake, then captures the returned prediction and republishes it as a registered result to the consumer (display/HPS side). It is the producer end of the network's image/prediction interface.

Parameters:
- IMG_W, 28, image width in pixels
- IMG_H, 28, image height in pixels
- THRESH, 8'd128, a pixel whose value is >= THRESH is binarized to 1
- NPIX, IMG_W*IMG_H, derived pixel count (784); not overridden

Ports:
- Clk  in  1  system clock, all logic rising-edge
- Reset  in  1  synchronous, active-high reset
- pix_valid  in  1  pixel beat valid
- pix_ready  out  1  loader can accept a pixel
- pix_data  in  8  grayscale pixel, row-major, index 0 = top-left
- pix_last  in  1  marks the final beat of a frame
- img_data  out  NPIX  packed binary image; bit i = pixel i
- img_valid  out  1  image stable and offered to the core
- img_ready  in  1  core accepts the image
- pred_valid  in  1  core prediction strobe, 1 cycle
- pred_in  in  5  core argmax output
- res_valid  out  1  result available
- res_ready  in  1  consumer takes the result
- res_digit  out  4  predicted digit, 0..9
- res_err  out  3  {bad_pred, long_frame, short_frame} for this frame

Behaviour:
- Reset: state=LOAD, pix_ready=1, img_valid=0, res_valid=0, img_data=0, res_digit=0, res_err=0, pixel counter=0. Reset that arrives mid-frame or mid-inference discards everything; any late pred_valid after reset is ignored, because LOAD ignores pred_valid.
- FSM states: LOAD -> DRAIN -> OFFER -> WAIT -> RESULT -> LOAD.
- LOAD: pix_ready=1. On each beat (pix_valid&pix_ready), write bit[cnt] = (pix_data>=THRESH) and increment cnt.
  - A beat with pix_last at cnt==NPIX-1 goes to OFFER.
  - A beat with pix_last at cnt<NPIX-1 zero-fills bits cnt+1..NPIX-1 (clear-on-start is acceptable: img_data is cleared when a new frame begins), sets short_frame and goes to OFFER.
  - A beat at cnt==NPIX-1 without pix_last sets long_frame and goes to DRAIN.
- DRAIN: pix_ready=1. Beats are discarded and img_data is unchanged. A beat with pix_last goes to OFFER.
- OFFER: pix_ready=0 and img_valid=1. img_data is held constant while img_valid=1. The state goes to WAIT in the cycle where img_ready=1; img_valid falls on the next cycle.
- WAIT: img_valid=0, pix_ready=0. On pred_valid, res_digit captures pred_in[3:0]. If pred_in>9, res_digit=0 and bad_pred is set. The state then goes to RESULT.
- RESULT: res_valid=1, with res_digit and res_err held. On res_ready, go to LOAD, clear cnt and error flags, and drop res_valid on the next cycle.
- Latency:
  - The first cycle img_valid can be high is the cycle after the accepted pix_last beat.
  - res_valid rises the cycle after pred_valid.
  - The next frame's first pixel is accepted the cycle after the res handshake.
- Simultaneous events:
  - pred_valid in the same cycle as the img_ready handshake is ignored, because the core must take at least 1 cycle.
  - pred_valid outside WAIT is ignored.
- Counter is 10 bits wide and never wraps; the saturating transition to DRAIN prevents overflow.

Optional Feature:
NN_IMAGE_LOADER_STATS_EN:
- Defined: adds outputs frame_cnt[15:0] and err_cnt[15:0].
  - frame_cnt increments on every res handshake.
  - err_cnt increments on every res handshake where res_err!=0.
  - Both counters wrap at 16'hFFFF to 0 and reset to 0.
- Undefined: the ports and logic are absent, and all other behaviour is identical.

Test Plan:
- Full frame of 784 beats, pixel i = (i%2 ? 8'd200 : 8'd10), pix_last on beat 783 -> img_data = {392{2'b10}}, img_valid the next cycle, res_err=0.
- Threshold edges: beat values 127, 128, 255, 0 -> bits 0, 1, 1, 0.
- Short frame: 100 beats of 8'hFF with pix_last on beat 99 -> bits 0..99 = 1, bits 100..783 = 0, short_frame=1.
- Long frame: 800 beats with pix_last on beat 799 -> pix_ready stays 1 through 799, the first 784 bits are kept, long_frame=1, img_valid rises after beat 799.
- Handshake: hold img_ready=0 for 5 cycles -> img_valid and img_data stable throughout. Then img_ready=1; pred_valid with pred_in=7 -> res_valid=1, res_digit=7 next cycle. Hold res_ready=0 for 3 cycles -> res_valid held and pix_ready=0.
- Bad prediction and reset: pred_in=5'd12 -> res_digit=0, bad_pred=1. Reset asserted mid-frame at cnt=300 -> the next cycle shows cnt=0, pix_ready=1, img_valid=0, res_valid=0. With STATS_EN, the counters read frame_cnt=1, err_cnt=1 after one bad-frame handshake.

Source files
------------

// File: rtl/nn_image_loader.sv
// Binarizing raster loader for the 28x28 digit network: packs pixels, offers the image, republishes the prediction.
// Optional statistics outputs (frame_cnt, err_cnt) are enabled by defining NN_IMAGE_LOADER_STATS_EN.
module nn_image_loader #(
    parameter int unsigned IMG_W  = 28,
    parameter int unsigned IMG_H  = 28,
    parameter logic [7:0]  THRESH = 8'd128,
    parameter int unsigned NPIX   = IMG_W * IMG_H
) (
    input  logic            Clk,
    input  logic            Reset,
    input  logic            pix_valid,
    output logic            pix_ready,
    input  logic [7:0]      pix_data,
    input  logic            pix_last,
    output logic [NPIX-1:0] img_data,
    output logic            img_valid,
    input  logic            img_ready,
    input  logic            pred_valid,
    input  logic [4:0]      pred_in,
    output logic            res_valid,
    input  logic            res_ready,
    output logic [3:0]      res_digit,
`ifdef NN_IMAGE_LOADER_STATS_EN
    output logic [15:0]     frame_cnt,
    output logic [15:0]     err_cnt,
`endif
    output logic [2:0]      res_err
);

    typedef enum logic [2:0] {LOAD, DRAIN, OFFER, WAIT, RESULT} state_t;

    localparam logic [9:0] LAST_IDX = 10'(NPIX - 1);

    state_t          state, state_next;
    logic [9:0]      cnt;
    logic            beat;
    logic            pix_bit;
    logic            res_done;
    logic            short_frame, long_frame, bad_pred;
    logic [NPIX-1:0] img_next;

    assign res_err = {bad_pred, long_frame, short_frame};
    assign pix_bit = (pix_data >= THRESH);

    // The image is cleared when the first beat of a frame lands, which
    // zero-fills the tail of short frames without a separate fill pass.
    always_comb begin
        img_next      = (cnt == '0) ? '0 : img_data;
        img_next[cnt] = pix_bit;
    end

    always_comb begin
        state_next = state;
        pix_ready  = 1'b0;
        img_valid  = 1'b0;
        res_valid  = 1'b0;
        beat       = 1'b0;
        res_done   = 1'b0;
        case (state)
            LOAD: begin
                pix_ready = 1'b1;
                beat      = pix_valid;
                if (pix_valid) begin
                    if (pix_last)
                        state_next = OFFER;
                    else if (cnt == LAST_IDX)
                        state_next = DRAIN;
                end
            end
            DRAIN: begin
                pix_ready = 1'b1;
                if (pix_valid && pix_last)
                    state_next = OFFER;
            end
            OFFER: begin
                img_valid = 1'b1;
                if (img_ready)
                    state_next = WAIT;
            end
            WAIT: begin
                if (pred_valid)
                    state_next = RESULT;
            end
            RESULT: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    res_done   = 1'b1;
                    state_next = LOAD;
                end
            end
            default: state_next = LOAD;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state       <= LOAD;
            cnt         <= '0;
            img_data    <= '0;
            res_digit   <= '0;
            short_frame <= 1'b0;
            long_frame  <= 1'b0;
            bad_pred    <= 1'b0;
        end else begin
            state <= state_next;
            if (beat) begin
                img_data <= img_next;
                cnt      <= cnt + 10'd1;
                if (pix_last && cnt != LAST_IDX)
                    short_frame <= 1'b1;
                if (!pix_last && cnt == LAST_IDX)
                    long_frame <= 1'b1;
            end
            if (state == WAIT && pred_valid) begin
                res_digit <= (pred_in > 5'd9) ? 4'd0 : pred_in[3:0];
                bad_pred  <= (pred_in > 5'd9);
            end
            if (res_done) begin
                cnt         <= '0;
                short_frame <= 1'b0;
                long_frame  <= 1'b0;
                bad_pred    <= 1'b0;
            end
        end
    end

`ifdef NN_IMAGE_LOADER_STATS_EN
    always_ff @(posedge Clk) begin
        if (Reset) begin
            frame_cnt <= '0;
            err_cnt   <= '0;
        end else if (res_done) begin
            frame_cnt <= frame_cnt + 16'd1;
            if (res_err != '0)
                err_cnt <= err_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_nn_image_loader.sv
// Self-checking bench for nn_image_loader: table-driven frames, threshold table, random frames vs. a pixel-array model.
// Statistics checks are compiled in when NN_IMAGE_LOADER_STATS_EN is defined.
module tb_nn_image_loader;

    localparam int NPIX = 784;

    logic            Clk;
    logic            Reset;
    logic            pix_valid;
    logic            pix_ready;
    logic [7:0]      pix_data;
    logic            pix_last;
    logic [NPIX-1:0] img_data;
    logic            img_valid;
    logic            img_ready;
    logic            pred_valid;
    logic [4:0]      pred_in;
    logic            res_valid;
    logic            res_ready;
    logic [3:0]      res_digit;
    logic [2:0]      res_err;
`ifdef NN_IMAGE_LOADER_STATS_EN
    logic [15:0]     frame_cnt;
    logic [15:0]     err_cnt;
`endif

    nn_image_loader #(.IMG_W(28), .IMG_H(28), .THRESH(8'd128)) dut (
        .Clk(Clk), .Reset(Reset),
        .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data), .pix_last(pix_last),
        .img_data(img_data), .img_valid(img_valid), .img_ready(img_ready),
        .pred_valid(pred_valid), .pred_in(pred_in),
        .res_valid(res_valid), .res_ready(res_ready), .res_digit(res_digit),
`ifdef NN_IMAGE_LOADER_STATS_EN
        .frame_cnt(frame_cnt), .err_cnt(err_cnt),
`endif
        .res_err(res_err)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int tests = 0;
    int fails = 0;
    int exp_frames = 0;
    int exp_errs = 0;

    logic [7:0]      pix [0:1023];
    logic [NPIX-1:0] exp_img;

    typedef struct {
        int         n;
        int         kind;
        logic [4:0] pred;
        logic [3:0] digit;
        logic [2:0] err;
    } frame_vec_t;

    typedef struct {
        logic [7:0] v;
        logic       b;
    } thr_vec_t;

    frame_vec_t fv [0:6];
    thr_vec_t   tv [0:5];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic chk_img(input string name, input logic [NPIX-1:0] got, input logic [NPIX-1:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got %h expected %h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic stats_check();
`ifdef NN_IMAGE_LOADER_STATS_EN
        chk("frame_cnt", 32'(frame_cnt), 32'(exp_frames[15:0]));
        chk("err_cnt", 32'(err_cnt), 32'(exp_errs[15:0]));
`endif
    endtask

    // kind: 0 alternating 10/200, 1 all 0xFF, 2 random, 3 threshold table then random
    task automatic send_frame(input int n, input int kind);
        int stalls;
        int guard;
        for (int i = 0; i < 1024; i++) begin
            case (kind)
                0:       pix[i] = (i % 2 != 0) ? 8'd200 : 8'd10;
                1:       pix[i] = 8'hFF;
                3:       pix[i] = (i < 6) ? tv[i].v : 8'($urandom_range(0, 255));
                default: pix[i] = 8'($urandom_range(0, 255));
            endcase
        end
        exp_img = '0;
        for (int i = 0; i < n && i < NPIX; i++)
            exp_img[i] = (pix[i] >= 8'd128);
        stalls = 0;
        pix_valid = 1'b1;
        for (int i = 0; i < n; i++) begin
            pix_data = pix[i];
            pix_last = (i == n - 1);
            guard = 0;
            while (!pix_ready && guard < 50) begin
                tick();
                guard++;
            end
            stalls += guard;
            if (guard == 50) break;
            tick();
        end
        pix_valid = 1'b0;
        pix_last  = 1'b0;
        chk("pix_no_stall", 32'(stalls), 32'd0);
    endtask

    task automatic run_frame(input int n, input int kind, input logic [4:0] pred,
                             input logic [3:0] ed, input logic [2:0] ee,
                             input int hold_img, input int hold_res);
        send_frame(n, kind);
        chk("img_valid_latency", 32'(img_valid), 32'd1);
        chk_img("img_data", img_data, exp_img);
        for (int c = 0; c < hold_img; c++) begin
            tick();
            chk("img_valid_hold", 32'(img_valid), 32'd1);
            chk_img("img_data_hold", img_data, exp_img);
        end
        // decoy prediction coincides with the image handshake and must be ignored
        img_ready = 1'b1; pred_valid = 1'b1; pred_in = 5'd4;
        tick();
        img_ready = 1'b0; pred_valid = 1'b0;
        chk("img_valid_drop", 32'(img_valid), 32'd0);
        chk("pix_ready_wait", 32'(pix_ready), 32'd0);
        tick();
        chk("res_valid_early", 32'(res_valid), 32'd0);
        pred_valid = 1'b1; pred_in = pred;
        tick();
        pred_valid = 1'b0;
        chk("res_valid_rise", 32'(res_valid), 32'd1);
        chk("res_digit", 32'(res_digit), 32'(ed));
        chk("res_err", 32'(res_err), 32'(ee));
        for (int c = 0; c < hold_res; c++) begin
            pred_valid = 1'b1; pred_in = 5'd2;
            tick();
            pred_valid = 1'b0;
            chk("res_valid_hold", 32'(res_valid), 32'd1);
            chk("pix_ready_result", 32'(pix_ready), 32'd0);
            chk("res_digit_hold", 32'(res_digit), 32'(ed));
        end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        exp_frames++;
        if (ee != 3'd0) exp_errs++;
        chk("res_valid_drop", 32'(res_valid), 32'd0);
        chk("pix_ready_next", 32'(pix_ready), 32'd1);
        stats_check();
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog expired got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NPIX-1:0] alt_img;
        int              n;
        logic [4:0]      p;
        logic [2:0]      e;

        fv[0] = '{784, 0, 5'd7,  4'd7, 3'b000};
        fv[1] = '{100, 1, 5'd9,  4'd9, 3'b001};
        fv[2] = '{800, 2, 5'd0,  4'd0, 3'b010};
        fv[3] = '{784, 2, 5'd12, 4'd0, 3'b100};
        fv[4] = '{1,   2, 5'd31, 4'd0, 3'b101};
        fv[5] = '{785, 2, 5'd10, 4'd0, 3'b110};
        fv[6] = '{783, 2, 5'd3,  4'd3, 3'b001};

        tv[0] = '{8'd127, 1'b0};
        tv[1] = '{8'd128, 1'b1};
        tv[2] = '{8'd255, 1'b1};
        tv[3] = '{8'd0,   1'b0};
        tv[4] = '{8'd129, 1'b1};
        tv[5] = '{8'd126, 1'b0};

        alt_img = {392{2'b10}};

        Reset = 1'b1; pix_valid = 1'b0; pix_data = '0; pix_last = 1'b0;
        img_ready = 1'b0; pred_valid = 1'b0; pred_in = '0; res_ready = 1'b0;
        tick(); tick();
        Reset = 1'b0;
        chk("rst_pix_ready", 32'(pix_ready), 32'd1);
        chk("rst_img_valid", 32'(img_valid), 32'd0);
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        chk_img("rst_img_data", img_data, '0);
        chk("rst_res_digit", 32'(res_digit), 32'd0);
        chk("rst_res_err", 32'(res_err), 32'd0);
        stats_check();

        for (int k = 0; k < 7; k++) begin
            run_frame(fv[k].n, fv[k].kind, fv[k].pred, fv[k].digit, fv[k].err,
                      (k == 0) ? 5 : 1, (k == 0) ? 3 : 1);
            if (fv[k].kind == 0)
                chk_img("alt_pattern", img_data, alt_img);
        end

        run_frame(784, 3, 5'd1, 4'd1, 3'b000, 0, 0);
        for (int k = 0; k < 6; k++)
            chk($sformatf("thresh_bit%0d", k), 32'(img_data[k]), 32'(tv[k].b));

        for (int r = 0; r < 4; r++) begin
            n = $urandom_range(1, 820);
            p = 5'($urandom_range(0, 31));
            e = {p > 5'd9, n > NPIX, n < NPIX};
            run_frame(n, 2, p, (p > 5'd9) ? 4'd0 : p[3:0], e, 2, 1);
        end

        // reset in the middle of a frame
        pix_valid = 1'b1;
        for (int i = 0; i < 300; i++) begin
            pix_data = 8'hFF;
            tick();
        end
        pix_valid = 1'b0;
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        exp_frames = 0; exp_errs = 0;
        chk("midrst_pix_ready", 32'(pix_ready), 32'd1);
        chk("midrst_img_valid", 32'(img_valid), 32'd0);
        chk("midrst_res_valid", 32'(res_valid), 32'd0);
        chk_img("midrst_img_data", img_data, '0);
        stats_check();

        // a full frame right after reset must carry no length error
        run_frame(784, 2, 5'd12, 4'd0, 3'b100, 0, 0);
`ifdef NN_IMAGE_LOADER_STATS_EN
        chk("stats_frame_one", 32'(frame_cnt), 32'd1);
        chk("stats_err_one", 32'(err_cnt), 32'd1);
`endif

        // reset during inference: a late prediction must be ignored
        send_frame(784, 2);
        img_ready = 1'b1;
        tick();
        img_ready = 1'b0;
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        exp_frames = 0; exp_errs = 0;
        pred_valid = 1'b1; pred_in = 5'd5;
        tick();
        pred_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            chk("late_pred_res_valid", 32'(res_valid), 32'd0);
            chk("late_pred_pix_ready", 32'(pix_ready), 32'd1);
            tick();
        end
        stats_check();

        run_frame(784, 0, 5'd8, 4'd8, 3'b000, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
